// File: rtl/mult_div_ctrl_if.sv
// Handshake/bus bundle between the main control FSM (master) and the
// mult/div sequencer (slave).
interface mult_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             MultOp;
    logic             DivOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output MultOp, DivOp, A, B,
        input  HI, LO, busy, done, div_zero
    );

    modport slave (
        input  MultOp, DivOp, A, B,
        output HI, LO, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_ctrl.sv
// Multi-cycle MIPS mult/div sequencer: radix-2 Booth signed multiply and
// restoring signed divide, one iteration per clock, owning HI/LO.
module mult_div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    mult_div_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, FINISH} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q, dz_q;
    // acc_q: Booth accumulator (one guard bit so a -2^(W-1) multiplicand
    // cannot overflow) / divide remainder / staged HI result.
    logic [WIDTH:0]     acc_q;
    // mplr_q: Booth multiplier / divide quotient / staged LO result.
    logic [WIDTH-1:0]   mplr_q;
    // mcand_q: latched multiplicand, or divisor magnitude.
    logic [WIDTH-1:0]   mcand_q;
    logic               qm1_q;
    logic               sa_q, sb_q;

    logic [WIDTH:0]     mcand_x, booth_sum, booth_acc_d;
    logic [WIDTH-1:0]   booth_mplr_d;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff, rem_d;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic               last_iter;

    // Datapath for one Booth step, one restoring-divide step and sign fix-up.
    always_comb begin
        mcand_x   = {mcand_q[WIDTH-1], mcand_q};
        booth_sum = acc_q;
        case ({mplr_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + mcand_x;
            2'b10:   booth_sum = acc_q - mcand_x;
            default: booth_sum = acc_q;
        endcase
        booth_acc_d  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_mplr_d = {booth_sum[0], mplr_q[WIDTH-1:1]};

        // Remainder is always below the divisor, so a W-bit subtract suffices.
        div_shift = {acc_q[WIDTH-1:0], mplr_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mcand_q});
        div_diff  = div_shift[WIDTH-1:0] - mcand_q;
        rem_d     = div_ge ? div_diff : div_shift[WIDTH-1:0];

        a_mag   = bus.A[WIDTH-1] ? ('0 - bus.A) : bus.A;
        b_mag   = bus.B[WIDTH-1] ? ('0 - bus.B) : bus.B;
        quo_fix = (sa_q ^ sb_q) ? ('0 - mplr_q) : mplr_q;
        rem_fix = sa_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];

        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Sequencer FSM with registered HI/LO and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            acc_q   <= '0;
            mplr_q  <= '0;
            mcand_q <= '0;
            qm1_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (bus.MultOp) begin
                        // MultOp has priority over a simultaneous DivOp.
                        mcand_q <= bus.A;
                        mplr_q  <= bus.B;
                        acc_q   <= '0;
                        qm1_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= MULT;
                    end else if (bus.DivOp) begin
                        if (bus.B == '0) begin
                            dz_q <= 1'b1;
                        end else begin
                            mcand_q <= b_mag;
                            mplr_q  <= a_mag;
                            acc_q   <= '0;
                            sa_q    <= bus.A[WIDTH-1];
                            sb_q    <= bus.B[WIDTH-1];
                            busy_q  <= 1'b1;
                            state_q <= DIV;
                        end
                    end
                end
                MULT: begin
                    acc_q  <= booth_acc_d;
                    mplr_q <= booth_mplr_d;
                    qm1_q  <= mplr_q[0];
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_iter) state_q <= FINISH;
                end
                DIV: begin
                    acc_q  <= {1'b0, rem_d};
                    mplr_q <= {mplr_q[WIDTH-2:0], div_ge};
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_iter) state_q <= FIX;
                end
                FIX: begin
                    // Truncate toward zero: remainder follows the dividend sign.
                    acc_q   <= {1'b0, rem_fix};
                    mplr_q  <= quo_fix;
                    state_q <= FINISH;
                end
                FINISH: begin
                    hi_q    <= acc_q[WIDTH-1:0];
                    lo_q    <= mplr_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: products, quotients, latency, hold,
// divide-by-zero, ignored strobes and asynchronous reset abort.
module tb_mult_div_ctrl;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    mult_div_ctrl_if #(.WIDTH(32)) bus ();

    mult_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts an op from a negedge; returns at the negedge where done is seen.
    // lat = edges from the start edge to done; bcnt = cycles busy was high;
    // held = HI/LO stayed unchanged while the op was in flight.
    task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input int intf,
                          output int lat, output int bcnt, output logic held);
        logic [31:0] hi0, lo0;
        hi0 = bus.HI;
        lo0 = bus.LO;
        bus.MultOp = m;
        bus.DivOp  = d;
        bus.A      = a;
        bus.B      = b;
        @(negedge clk);
        bus.MultOp = 1'b0;
        bus.DivOp  = 1'b0;
        bus.A      = $urandom;
        bus.B      = $urandom;
        lat  = 0;
        bcnt = 0;
        held = 1'b1;
        while (!bus.done && lat < 100) begin
            if (bus.busy) bcnt++;
            if (bus.HI !== hi0 || bus.LO !== lo0) held = 1'b0;
            if (lat == intf) begin
                bus.DivOp = 1'b1;
                bus.A     = 32'h8000_0000;
                bus.B     = 32'hFFFF_FFFF;
            end
            if (lat == intf + 1) bus.DivOp = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, bcnt;
        logic held, seen;
        logic [31:0] hi_s, lo_s;

        reset_n    = 1'b0;
        bus.MultOp = 1'b0;
        bus.DivOp  = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_hi",   bus.HI, 0);
        check("rst_lo",   bus.LO, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dz",   bus.div_zero, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // 7 * -3 = -21
        run_op(1, 0, 32'd7, 32'hFFFF_FFFD, -5, lat, bcnt, held);
        check("m1_lat",  lat, 33);
        check("m1_busy", bcnt, 33);
        check("m1_bz",   bus.busy, 0);
        check("m1_hi",   bus.HI, 32'hFFFF_FFFF);
        check("m1_lo",   bus.LO, 32'hFFFF_FFEB);

        // Next start lands in the done cycle: (-2^31)^2 = 2^62
        run_op(1, 0, 32'h8000_0000, 32'h8000_0000, -5, lat, bcnt, held);
        check("m2_held", held, 1);
        check("m2_lat",  lat, 33);
        check("m2_hi",   bus.HI, 32'h4000_0000);
        check("m2_lo",   bus.LO, 32'h0000_0000);

        // -1 * -1 = 1
        run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -5, lat, bcnt, held);
        check("m3_hi", bus.HI, 0);
        check("m3_lo", bus.LO, 1);

        // -7 / 2 = -3 rem -1
        run_op(0, 1, 32'hFFFF_FFF9, 32'd2, -5, lat, bcnt, held);
        check("d1_lat",  lat, 34);
        check("d1_busy", bcnt, 34);
        check("d1_held", held, 1);
        check("d1_lo",   bus.LO, 32'hFFFF_FFFD);
        check("d1_hi",   bus.HI, 32'hFFFF_FFFF);

        // 7 / -2 = -3 rem 1
        run_op(0, 1, 32'd7, 32'hFFFF_FFFE, -5, lat, bcnt, held);
        check("d2_lo", bus.LO, 32'hFFFF_FFFD);
        check("d2_hi", bus.HI, 32'h0000_0001);

        // Preload HI/LO: 0x451 / 0x20 = 0x22 rem 0x11
        run_op(0, 1, 32'h451, 32'h20, -5, lat, bcnt, held);
        check("pre_lo", bus.LO, 32'h22);
        check("pre_hi", bus.HI, 32'h11);

        // Divide by zero
        @(negedge clk);
        bus.DivOp = 1'b1;
        bus.A     = 32'd5;
        bus.B     = 32'd0;
        @(negedge clk);
        bus.DivOp = 1'b0;
        check("dz_pulse", bus.div_zero, 1);
        check("dz_busy",  bus.busy, 0);
        check("dz_done",  bus.done, 0);
        @(negedge clk);
        check("dz_off", bus.div_zero, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy || bus.done || bus.div_zero) seen = 1'b1;
            @(negedge clk);
        end
        check("dz_quiet", seen, 0);
        check("dz_hi", bus.HI, 32'h11);
        check("dz_lo", bus.LO, 32'h22);

        // Mult with DivOp pulse and operand changes mid-flight
        run_op(1, 0, 32'h1234, 32'h100, 10, lat, bcnt, held);
        check("ig_lat", lat, 33);
        check("ig_hi",  bus.HI, 0);
        check("ig_lo",  bus.LO, 32'h0012_3400);
        @(negedge clk);
        check("ig_idle", bus.busy, 0);

        // Overflow: -2^31 / -1
        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, -5, lat, bcnt, held);
        check("ov_lo", bus.LO, 32'h8000_0000);
        check("ov_hi", bus.HI, 0);
        hi_s = bus.HI;
        lo_s = bus.LO;
        check("ov_lo_nz", (lo_s != 0), 1);

        // Reset mid-divide
        bus.DivOp = 1'b1;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        @(negedge clk);
        bus.DivOp = 1'b0;
        for (int i = 0; i < 15; i++) @(negedge clk);
        check("ar_busy_pre", bus.busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_hi",   bus.HI, 0);
        check("ar_lo",   bus.LO, 0);
        check("ar_busy", bus.busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("ar_quiet", seen, 0);

        // 6 * 7 = 42 after reset
        run_op(1, 0, 32'd6, 32'd7, -5, lat, bcnt, held);
        check("pr_lat", lat, 33);
        check("pr_hi",  bus.HI, 0);
        check("pr_lo",  bus.LO, 32'd42);
        @(negedge clk);
        check("pr_done_pulse", bus.done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
